// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults, FSM encoding and port indices for the RAM arbiter
package ram_pkg;

  localparam int ADDR_DEF = 15;
  localparam int DATA_DEF = 8;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Round-robin choice when both ports ask: whoever was not served last.
  function automatic logic rr_winner(input logic [1:0] req_valid, input logic last);
    if (req_valid[PORT_CPU] && req_valid[PORT_DMA])
      return ~last;
    return req_valid[PORT_DMA];
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner select; RAM_ARB_FIXED_PRIO_EN gives port 0 strict priority
module ram_arb_pick
  import ram_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic       any_req,
  output logic       winner
);

  always_comb begin
    any_req = |req_valid;
    winner  = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    winner  = ~req_valid[PORT_CPU];
`else
    winner  = rr_winner(req_valid, last);
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter for a single-port synchronous RAM
// Optional RAM_ARB_FIXED_PRIO_EN selects fixed priority for port 0 instead of round-robin.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_  = ADDR_DEF,
  parameter int DATA_  = DATA_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_we,
  input  logic [2*ADDR_-1:0]   req_addr,
  input  logic [2*DATA_-1:0]   req_wdata,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [DATA_-1:0]     rsp_rdata,
  output logic [ADDR_-1:0]     a,
  output logic [DATA_-1:0]     d,
  input  logic [DATA_-1:0]     q,
  output logic                 rd,
  output logic                 wr
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t           state;
  logic             last;
  logic             owner;
  logic [1:0]       cnt;
  logic             any_req;
  logic             winner;
  logic [ADDR_-1:0] sel_addr;
  logic [DATA_-1:0] sel_wdata;
  logic             sel_we;

  ram_arb_pick u_pick (
    .req_valid (req_valid),
    .last      (last),
    .any_req   (any_req),
    .winner    (winner)
  );

  always_comb begin
    sel_addr  = winner ? req_addr[PORT_DMA*ADDR_ +: ADDR_]  : req_addr[PORT_CPU*ADDR_ +: ADDR_];
    sel_wdata = winner ? req_wdata[PORT_DMA*DATA_ +: DATA_] : req_wdata[PORT_CPU*DATA_ +: DATA_];
    sel_we    = winner ? req_we[PORT_DMA] : req_we[PORT_CPU];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      a         <= '0;
      d         <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner             <= winner;
            last              <= winner;
            a                 <= sel_addr;
            d                 <= sel_wdata;
            wr                <= sel_we;
            rd                <= ~sel_we;
            req_ready[winner] <= 1'b1;
            state             <= ST_ACCESS;
          end else begin
            rd <= 1'b0;
            wr <= 1'b0;
          end
        end
        // The RAM samples the strobes on the edge leaving this state; a and d stay put afterwards.
        ST_ACCESS: begin
          rd <= 1'b0;
          wr <= 1'b0;
          if (wr) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= LAT_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            rsp_rdata        <= q;
            rsp_valid[owner] <= 1'b1;
            state            <= ST_IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          rd    <= 1'b0;
          wr    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench with behavioural RAM and transaction-level model
module tb_ram_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   a;
  logic [DW-1:0]   d;
  logic [DW-1:0]   q;
  logic            rd;
  logic            wr;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_(AW), .DATA_(DW), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .a         (a),
    .d         (d),
    .q         (q),
    .rd        (rd),
    .wr        (wr)
  );

  // Behavioural RAM: q becomes valid LAT cycles after the edge that samples rd.
  logic [DW-1:0] mem [0:32767];
  logic [DW-1:0] qp [0:LAT-1];
  assign q = qp[LAT-1];

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) qp[i] = '0;
    forever begin
      @(posedge clk);
      for (int i = LAT - 1; i > 0; i--) qp[i] <= qp[i-1];
      if (rd) qp[0] <= mem[a];
      if (wr) mem[a] <= d;
    end
  end

  typedef struct {
    int port;
    int we;
    int addr;
    int data;
    int a;
    int d;
    int cyc;
  } ev_t;

  typedef struct {
    int we;
    int addr;
    int data;
  } rq_t;

  int  cyc = 0;
  ev_t g_q[$];
  ev_t r_q[$];
  int  both_strobe = 0;
  int  dual_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    for (int p = 0; p < 2; p++) begin
      if (req_ready[p]) begin
        e.port = p;
        e.we   = int'(req_we[p]);
        e.addr = int'(req_addr[p*AW +: AW]);
        e.data = int'(req_wdata[p*DW +: DW]);
        e.a    = int'(a);
        e.d    = int'(d);
        e.cyc  = cyc;
        g_q.push_back(e);
      end
    end
    if (|rsp_valid) begin
      e.port = rsp_valid[1] ? 1 : 0;
      e.we   = 0;
      e.addr = 0;
      e.data = int'(rsp_rdata);
      e.a    = int'(rsp_valid);
      e.d    = 0;
      e.cyc  = cyc;
      r_q.push_back(e);
    end
    if (rd && wr) both_strobe++;
    if (req_ready == 2'b11) dual_ready++;
  end

  // Transaction-level reference: memory image plus who was served last.
  logic [DW-1:0] ref_mem [0:32767];
  int model_last = 1;
  int g_done = 0;
  int r_done = 0;
  int checks = 0;
  int passed = 0;
  rq_t q0[$];
  rq_t q1[$];

  function automatic void model_apply(input ev_t e);
    if (e.we != 0) ref_mem[e.addr] = e.data[DW-1:0];
    model_last = e.port;
  endfunction

  task automatic catchup();
    while (g_done < g_q.size()) begin
      if (g_q[g_done].we == 0 && r_done < r_q.size()) r_done++;
      model_apply(g_q[g_done]);
      g_done++;
    end
  endtask

  task automatic issue(input int p, input int we, input int addr, input int data, output bit to);
    req_valid[p]           = 1'b1;
    req_we[p]              = we[0];
    req_addr[p*AW +: AW]   = addr[AW-1:0];
    req_wdata[p*DW +: DW]  = data[DW-1:0];
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (req_ready[p]) begin
        to = 1'b0;
        break;
      end
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (r_q.size() >= n) begin
        to = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic load_port(input int p);
    rq_t r;
    if (p == 0 && q0.size() > 0) begin
      r = q0.pop_front();
    end else if (p == 1 && q1.size() > 0) begin
      r = q1.pop_front();
    end else begin
      req_valid[p] = 1'b0;
      return;
    end
    req_valid[p]          = 1'b1;
    req_we[p]             = r.we[0];
    req_addr[p*AW +: AW]  = r.addr[AW-1:0];
    req_wdata[p*DW +: DW] = r.data[DW-1:0];
  endtask

  task automatic run_both(output bit to);
    load_port(0);
    load_port(1);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (req_ready[0]) load_port(0);
      if (req_ready[1]) load_port(1);
      if (req_valid == 2'b00) begin
        to = 1'b0;
        break;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd !== 1'b0) $display("FAIL reset_rd got=%b exp=0", rd); else passed++;
    checks++; if (wr !== 1'b0) $display("FAIL reset_wr got=%b exp=0", wr); else passed++;
    checks++; if (a !== '0) $display("FAIL reset_a got=%0d exp=0", a); else passed++;
    checks++; if (d !== '0) $display("FAIL reset_d got=%0h exp=0", d); else passed++;
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else passed++;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else passed++;
    checks++; if (rsp_rdata !== '0) $display("FAIL reset_rsp_rdata got=%0h exp=0", rsp_rdata); else passed++;
    reset_n = 1'b1;
    model_last = 1;
    @(negedge clk); #1;
  endtask

  task automatic test_write_readback();
    int wa[3] = '{1234, 1235, 1236};
    int wd[3] = '{'hAA, 'h55, 'hFF};
    int rs;
    bit to;
    ev_t g, r;
    for (int i = 0; i < 3; i++) begin
      issue(0, 1, wa[i], wd[i], to);
      checks++; if (to) $display("FAIL wr_accept_timeout idx=%0d got=timeout exp=req_ready", i); else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      rs = r_q.size();
      issue(0, 0, wa[i], 0, to);
      wait_rsp(rs + 1, to);
      checks++;
      if (to) begin
        $display("FAIL rd_rsp_timeout idx=%0d got=none exp=rsp_valid", i);
        continue;
      end
      passed++;
      g = g_q[g_q.size()-1];
      r = r_q[rs];
      checks++; if (r.data != wd[i]) $display("FAIL rd_data idx=%0d got=%0h exp=%0h", i, r.data, wd[i]); else passed++;
      checks++; if (r.a != 1) $display("FAIL rd_rsp_port idx=%0d got=%b exp=01", i, r.a); else passed++;
      checks++; if (r.cyc - g.cyc != LAT + 1) $display("FAIL rd_latency idx=%0d got=%0d exp=%0d", i, r.cyc - g.cyc, LAT + 1); else passed++;
    end
    catchup();
  endtask

  task automatic test_top_address();
    int rs;
    bit to;
    issue(1, 1, 32767, 'h42, to);
    checks++; if (to) $display("FAIL top_wr_timeout got=timeout exp=req_ready"); else passed++;
    checks++; if (g_q[g_q.size()-1].a != 32767) $display("FAIL top_wr_addr got=%0d exp=32767", g_q[g_q.size()-1].a); else passed++;
    rs = r_q.size();
    issue(1, 0, 32767, 0, to);
    wait_rsp(rs + 1, to);
    checks++;
    if (to) $display("FAIL top_rd_timeout got=none exp=rsp_valid");
    else if (r_q[rs].data != 'h42 || r_q[rs].a != 2) $display("FAIL top_rd got=%0h/%b exp=42/10", r_q[rs].data, r_q[rs].a);
    else passed++;
    catchup();
  endtask

  task automatic test_simultaneous();
    bit to;
    int rs, k;
    ev_t e;
    int exp_data;
    rs = r_q.size();
    q0.push_back('{1, 10, 'h11});
    q1.push_back('{1, 20, 'h22});
    run_both(to);
    checks++; if (to) $display("FAIL sim_wr_timeout got=timeout exp=done"); else passed++;
    q0.push_back('{0, 10, 0});
    q1.push_back('{0, 20, 0});
    run_both(to);
    checks++; if (to) $display("FAIL sim_rd_timeout got=timeout exp=done"); else passed++;
    wait_rsp(rs + 2, to);
    checks++; if (to) $display("FAIL sim_rsp_timeout got=%0d exp=%0d", r_q.size() - rs, 2); else passed++;
    k = 0;
    while (g_done < g_q.size()) begin
      e = g_q[g_done];
      checks++; if (e.port != k % 2) $display("FAIL sim_grant_order k=%0d got=%0d exp=%0d", k, e.port, k % 2); else passed++;
      if (e.we == 0 && r_done < r_q.size()) begin
        exp_data = (e.port == 0) ? 'h11 : 'h22;
        checks++;
        if (r_q[r_done].data != exp_data || r_q[r_done].port != e.port)
          $display("FAIL sim_rd_data k=%0d got=%0h@%0d exp=%0h@%0d", k, r_q[r_done].data, r_q[r_done].port, exp_data, e.port);
        else passed++;
        r_done++;
      end
      model_apply(e);
      g_done++;
      k++;
    end
  endtask

  task automatic test_reset_mid_read();
    bit to;
    int rs;
    rs = r_q.size();
    issue(0, 0, 1234, 0, to);
    checks++; if (to) $display("FAIL rst_rd_accept got=timeout exp=req_ready"); else passed++;
    @(negedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd !== 1'b0 || wr !== 1'b0) $display("FAIL rst_mid_strobes got=%b%b exp=00", rd, wr); else passed++;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_mid_rsp got=%b exp=00", rsp_valid); else passed++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (r_q.size() != rs) $display("FAIL rst_no_rsp got=%0d exp=%0d", r_q.size(), rs); else passed++;
    g_done = g_q.size();
    r_done = r_q.size();
    model_last = 1;
    q0.push_back('{1, 300, 'h5A});
    q1.push_back('{1, 301, 'hA5});
    run_both(to);
    checks++; if (to) $display("FAIL rst_after_timeout got=timeout exp=done"); else passed++;
    checks++; if (g_q[g_done].port != 0) $display("FAIL rst_first_winner got=%0d exp=0", g_q[g_done].port); else passed++;
    catchup();
  endtask

  task automatic test_back_to_back();
    bit to;
    int rs, k, nreads, p0_cnt, exp_port, exp_data;
    ev_t e;
    int gs;
    rs = r_q.size();
    gs = g_q.size();
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{int'($urandom_range(0, 1)), int'($urandom_range(0, 32767)), int'($urandom_range(0, 255))});
      q1.push_back('{int'($urandom_range(0, 1)), int'($urandom_range(0, 32767)), int'($urandom_range(0, 255))});
    end
    run_both(to);
    checks++; if (to) $display("FAIL b2b_timeout got=timeout exp=done"); else passed++;
    nreads = 0;
    for (int i = gs; i < g_q.size(); i++) if (g_q[i].we == 0) nreads++;
    wait_rsp(rs + nreads, to);
    checks++; if (to) $display("FAIL b2b_rsp_timeout got=%0d exp=%0d", r_q.size() - rs, nreads); else passed++;
    checks++; if (g_q.size() - gs != 16) $display("FAIL b2b_grant_count got=%0d exp=16", g_q.size() - gs); else passed++;
    k = 0;
    p0_cnt = 0;
    while (g_done < g_q.size()) begin
      e = g_q[g_done];
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_port = (k < 8) ? 0 : 1;
`else
      exp_port = 1 - model_last;
`endif
      if (k < 8 && e.port == 0) p0_cnt++;
      checks++; if (e.port != exp_port) $display("FAIL b2b_grant k=%0d got=%0d exp=%0d", k, e.port, exp_port); else passed++;
      checks++; if (e.a != e.addr) $display("FAIL b2b_addr k=%0d got=%0d exp=%0d", k, e.a, e.addr); else passed++;
      if (e.we != 0) begin
        checks++; if (e.d != e.data) $display("FAIL b2b_wdata k=%0d got=%0h exp=%0h", k, e.d, e.data); else passed++;
      end else if (r_done < r_q.size()) begin
        exp_data = int'(ref_mem[e.addr]);
        checks++;
        if (r_q[r_done].data != exp_data || r_q[r_done].port != e.port)
          $display("FAIL b2b_rd k=%0d got=%0h@%0d exp=%0h@%0d", k, r_q[r_done].data, r_q[r_done].port, exp_data, e.port);
        else passed++;
        r_done++;
      end
      model_apply(e);
      g_done++;
      k++;
    end
`ifdef RAM_ARB_FIXED_PRIO_EN
    checks++; if (p0_cnt != 8) $display("FAIL b2b_p0_share got=%0d exp=8", p0_cnt); else passed++;
`else
    checks++; if (p0_cnt != 4) $display("FAIL b2b_p0_share got=%0d exp=4", p0_cnt); else passed++;
`endif
    checks++; if (both_strobe != 0) $display("FAIL rd_wr_overlap got=%0d exp=0", both_strobe); else passed++;
    checks++; if (dual_ready != 0) $display("FAIL dual_ready got=%0d exp=0", dual_ready); else passed++;
  endtask

  task automatic test_drop_request();
    bit to;
    int rs, gs, p0_grants;
    rs = r_q.size();
    gs = g_q.size();
    issue(1, 0, 500, 0, to);
    checks++; if (to) $display("FAIL drop_p1_timeout got=timeout exp=req_ready"); else passed++;
    req_valid[0]            = 1'b1;
    req_we[0]               = 1'b1;
    req_addr[0 +: AW]       = AW'(600);
    req_wdata[0 +: DW]      = 8'h99;
    @(negedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(rs + 1, to);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (to) $display("FAIL drop_rsp_timeout got=none exp=rsp_valid");
    else if (r_q[rs].data != int'(ref_mem[500]) || r_q[rs].port != 1)
      $display("FAIL drop_rsp got=%0h@%0d exp=%0h@1", r_q[rs].data, r_q[rs].port, ref_mem[500]);
    else passed++;
    p0_grants = 0;
    for (int i = gs; i < g_q.size(); i++) if (g_q[i].port == 0) p0_grants++;
    checks++; if (p0_grants != 0) $display("FAIL drop_no_ready0 got=%0d exp=0", p0_grants); else passed++;
    checks++; if (mem[600] !== ref_mem[600]) $display("FAIL drop_mem_unchanged got=%0h exp=%0h", mem[600], ref_mem[600]); else passed++;
    catchup();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = '0;
    test_reset();
    test_write_readback();
    test_top_address();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    test_drop_request();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
